// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM encoding, frame geometry, bit positions.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RX    = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    localparam int FRAME_BITS = 11;             // start + 8 data + parity + stop
    localparam int DATA_BITS  = 8;
    localparam int SHIFT_BITS = FRAME_BITS - 1; // start bit is consumed by IDLE
    localparam int PAR_POS    = 8;
    localparam int STOP_POS   = 9;

    // Odd parity holds when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [SHIFT_BITS-1:0] sh);
        return ^sh[PAR_POS:0];
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO for received scancodes.
// Latency: push visible on rd_data/count one cycle later; pop updates head next cycle.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
module ps2_rx_fifo #(
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    always_comb begin
        do_pop   = rd_en && !empty;
        do_push  = wr_en && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_pop  ? 1'b1 : 1'b0);
    end

    // Pointer registers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: sync, glitch filter, 11-bit deframer, checks, FWFT FIFO.
// Latency: stop-bit edge N -> status pulse N+1 -> rx_valid/count N+2.
// Backpressure: none on the bus; a good byte arriving at a full FIFO is dropped and flagged.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter  int FILTER_LEN = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int TIMEOUT    = 50000,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1,
    localparam int TW         = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2d,
    input  logic          ps2c,
    input  logic          rd_en,
    input  logic          clr_overflow,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic [CW-1:0] count,
    output logic          rx_done_tick,
    output logic          err_parity,
    output logic          err_frame,
    output logic          overflow
);

    logic                  c_meta_q, c_sync_q;
    logic                  d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  f_val_q, f_val_d;
    logic                  neg_edge;

    ps2_state_e            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d;

    logic                  fifo_wr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  ovf_set;
    logic                  ovf_q, ovf_d;

    // Two-flop synchronisers; idle-high reset so no false start after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2c;
            c_sync_q <= c_meta_q;
            d_meta_q <= ps2d;
            d_sync_q <= d_meta_q;
        end
    end

    // Clock filter: a level is only accepted after FILTER_LEN identical samples.
    always_comb begin
        f_val_d = f_val_q;
        if (&filt_q) begin
            f_val_d = 1'b1;
        end else if (~|filt_q) begin
            f_val_d = 1'b0;
        end
    end

    assign neg_edge = f_val_q & ~f_val_d;

    // Filter shift register and accepted clock level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q  <= '1;
            f_val_q <= 1'b1;
        end else begin
            filt_q  <= {c_sync_q, filt_q[FILTER_LEN-1:1]};
            f_val_q <= f_val_d;
        end
    end

    // Deframer next-state, status pulses and FIFO write request.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        shift_d      = shift_q;
        fifo_wr      = 1'b0;
        rx_done_tick = 1'b0;
        err_parity   = 1'b0;
        err_frame    = 1'b0;
        ovf_set      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (neg_edge && !d_sync_q) begin
                    state_d   = ST_RX;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            ST_RX: begin
                if (neg_edge) begin
                    shift_d   = {d_sync_q, shift_q[SHIFT_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    timer_d   = '0;
                    if (bit_cnt_q == 4'(SHIFT_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Clock stalled mid-frame: abandon it.
                    err_frame = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!shift_q[STOP_POS]) begin
                    err_frame = 1'b1;
                end else if (!odd_parity_ok(shift_q)) begin
                    err_parity = 1'b1;
                end else if (fifo_full && !rd_en) begin
                    ovf_set = 1'b1;
                end else begin
                    fifo_wr      = 1'b1;
                    rx_done_tick = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Deframer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
    assign rx_valid = !fifo_empty;

    ps2_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (shift_q[DATA_BITS-1:0]),
        .rd_en   (rd_en),
        .rd_data (rx_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

endmodule

// File: tb/tb_ps2_receiver.sv
// Testbench for ps2_receiver: bus-level frame driver, queue reference model, scenario tasks.
// Latency: n/a.
// Backpressure: pops issued by the bench at its own pace.
module tb_ps2_receiver;

    localparam int L     = 8;
    localparam int DEPTH = 16;
    localparam int TOUT  = 200;
    localparam int BIT   = 40;   // bus bit period in clk cycles
    localparam int Q     = 10;   // ps2c falls this many cycles into the bit
    localparam int HALF  = 20;   // ps2c low time

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] count;
    logic       rx_done_tick;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;
    int         e_done = 0, e_par = 0, e_frm = 0;

    // Observed pulse statistics
    int n_done = 0, n_par = 0, n_frm = 0;
    int n_multi = 0, n_long = 0, n_lat = 0;
    logic p_done = 1'b0, p_par = 1'b0, p_frm = 1'b0;

    always #5 clk = ~clk;

    ps2_receiver #(
        .FILTER_LEN (L),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .count        (count),
        .rx_done_tick (rx_done_tick),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .overflow     (overflow)
    );

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            p_done = 1'b0; p_par = 1'b0; p_frm = 1'b0;
        end else begin
            if (rx_done_tick === 1'b1) n_done++;
            if (err_parity === 1'b1) n_par++;
            if (err_frame === 1'b1) n_frm++;
            if (int'(rx_done_tick === 1'b1) + int'(err_parity === 1'b1) + int'(err_frame === 1'b1) > 1) n_multi++;
            if ((rx_done_tick && p_done) || (err_parity && p_par) || (err_frame && p_frm)) n_long++;
            if (p_done && rx_valid !== 1'b1) n_lat++;
            p_done = rx_done_tick; p_par = err_parity; p_frm = err_frame;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame as sent on the wire, LSB first: start, data[7:0], parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic par;
        par = ~(^d) ^ par_bad;
        return {~stop_bad, par, d, 1'b0};
    endfunction

    // Drive the first nbits of a frame; optionally pulse rd_en in the cycle the frame is judged.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_on_stop);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < BIT; c++) begin
                tick();
                if (c == 0) ps2d = bits[b];
                if (c == Q) ps2c = 1'b0;
                if (c == Q + HALF) ps2c = 1'b1;
                // 2 sync stages + L filter stages + 1 cycle to the judging cycle
                if (pop_on_stop && b == 10) rd_en = (c == Q + L + 3);
            end
        end
        ps2d  = 1'b1;
        rd_en = 1'b0;
    endtask

    // Spec-level outcome of one complete frame.
    task automatic model_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad, input bit pop);
        bit was_full, popped;
        was_full = (exp_q.size() == DEPTH);
        popped   = pop && (exp_q.size() > 0);
        if (popped) void'(exp_q.pop_front());
        if (stop_bad) e_frm++;
        else if (par_bad) e_par++;
        else if (was_full && !pop) exp_ovf = 1'b1;
        else begin
            exp_q.push_back(d);
            e_done++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad, input bit pop);
        send_bits(frame_bits(d, par_bad, stop_bad), 11, pop);
        model_frame(d, par_bad, stop_bad, pop);
    endtask

    task automatic pop_one();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
        vectors++; if ({rx_done_tick, err_parity, err_frame} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses got %b want 000", {rx_done_tick, err_parity, err_frame}); end
        reset = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_single();
        int d0;
        d0 = n_done;
        send_frame(8'h1C, 0, 0, 0);
        vectors++; if (n_done - d0 !== 1) begin miscompares++; $display("FAIL single_done got %0d pulses want 1", n_done - d0); end
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", rx_valid); end
        vectors++; if (rx_data !== 8'h1C) begin miscompares++; $display("FAIL single_data got %h want 1c", rx_data); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        pop_one();
        vectors++; if (rx_valid !== 1'b0 || count !== 5'd0) begin miscompares++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", rx_valid, count); end
    endtask

    task automatic test_parity();
        int p0;
        p0 = n_par;
        send_frame(8'hF0, 1, 0, 0);
        vectors++; if (n_par - p0 !== 1) begin miscompares++; $display("FAIL parity_err got %0d pulses want 1", n_par - p0); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL parity_count got %0d want 0", count); end
        send_frame(8'hF0, 0, 0, 0);
        vectors++; if (count !== 5'd1 || rx_data !== 8'hF0) begin miscompares++; $display("FAIL parity_good got count=%0d data=%h want 1/f0", count, rx_data); end
        pop_one();
    endtask

    task automatic test_stop();
        int f0;
        f0 = n_frm;
        send_frame(8'h55, 0, 1, 0);
        vectors++; if (n_frm - f0 !== 1) begin miscompares++; $display("FAIL stop_err got %0d pulses want 1", n_frm - f0); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL stop_count got %0d want 0", count); end
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int first, f0;
        f0 = n_frm;
        first = 0;
        bits = frame_bits(8'h3C, 0, 0);
        send_bits(bits, 4, 0);            // start + 3 data bits
        for (int c = 0; c <= Q; c++) begin // 4th data bit: last falling edge
            tick();
            if (c == 0) ps2d = bits[4];
            if (c == Q) ps2c = 1'b0;
        end
        for (int j = 1; j <= L + TOUT + 40; j++) begin
            tick();
            if (j == HALF) begin ps2c = 1'b1; ps2d = 1'b1; end
            if (err_frame === 1'b1 && first == 0) first = j;
        end
        e_frm++;
        // edge reaches the deframer 2 + L cycles after the fall, then TOUT cycles to abort
        vectors++; if (first !== 2 + L + TOUT) begin miscompares++; $display("FAIL timeout_cycle got %0d want %0d", first, 2 + L + TOUT); end
        vectors++; if (n_frm - f0 !== 1) begin miscompares++; $display("FAIL timeout_pulses got %0d want 1", n_frm - f0); end
        send_frame(8'hAA, 0, 0, 0);
        vectors++; if (count !== 5'd1 || rx_data !== 8'hAA) begin miscompares++; $display("FAIL timeout_next got count=%0d data=%h want 1/aa", count, rx_data); end
        pop_one();
    endtask

    task automatic test_overflow();
        int d0;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 0);
        vectors++; if (count !== 5'(DEPTH)) begin miscompares++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow); end
        vectors++; if (rx_data !== 8'h01) begin miscompares++; $display("FAIL ovf_head got %h want 01", rx_data); end
        tick(); clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", overflow); end
        d0 = n_done;
        send_frame(8'h12, 0, 0, 1);
        vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_pop_push got overflow=%b want %b", overflow, exp_ovf); end
        vectors++; if (n_done - d0 !== 1 || count !== 5'(exp_q.size())) begin miscompares++; $display("FAIL ovf_pop_push got done=%0d count=%0d want 1/%0d", n_done - d0, count, exp_q.size()); end
        while (exp_q.size() > 0) begin
            vectors++; if (rx_data !== exp_q[0]) begin miscompares++; $display("FAIL drain_order got %h want %h", rx_data, exp_q[0]); end
            pop_one();
        end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch_reset();
        int d0, p0, f0;
        logic [7:0] d;
        d0 = n_done; p0 = n_par; f0 = n_frm;
        ps2d = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick(); ps2c = 1'b0;
            repeat (L - 1) tick();
            ps2c = 1'b1;
            repeat (25) tick();
        end
        ps2d = 1'b1;
        repeat (5) tick();
        vectors++; if (n_done != d0 || n_par != p0 || n_frm != f0 || count !== 5'd0) begin miscompares++; $display("FAIL glitch_quiet got done=%0d par=%0d frm=%0d count=%0d want no change", n_done - d0, n_par - p0, n_frm - f0, count); end
        d = 8'($urandom);
        send_frame(d, 0, 0, 0);
        vectors++; if (count !== 5'd1 || rx_data !== d) begin miscompares++; $display("FAIL glitch_frame got count=%0d data=%h want 1/%h", count, rx_data, d); end
        send_bits(frame_bits(8'h77, 0, 0), 5, 0);
        tick(); #2 reset = 1'b0; #1;
        exp_q.delete(); exp_ovf = 1'b0;
        vectors++; if (rx_valid !== 1'b0 || count !== 5'd0 || rx_data !== 8'h00 || overflow !== 1'b0) begin miscompares++; $display("FAIL midreset_outputs got valid=%b count=%0d data=%h ovf=%b want 0", rx_valid, count, rx_data, overflow); end
        vectors++; if ({rx_done_tick, err_parity, err_frame} !== 3'b000) begin miscompares++; $display("FAIL midreset_pulses got %b want 000", {rx_done_tick, err_parity, err_frame}); end
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        d = 8'($urandom);
        send_frame(d, 0, 0, 0);
        vectors++; if (count !== 5'd1 || rx_data !== d) begin miscompares++; $display("FAIL midreset_next got count=%0d data=%h want 1/%h", count, rx_data, d); end
        pop_one();
    endtask

    task automatic test_random();
        logic [7:0] d;
        int kind, d0, p0, f0, npop;
        for (int it = 0; it < 24; it++) begin
            d0 = e_done - n_done; p0 = e_par - n_par; f0 = e_frm - n_frm;
            d = 8'($urandom);
            kind = $urandom_range(0, 5);
            send_frame(d, kind == 0, kind == 1, 0);
            vectors++; if ((e_done - n_done) != d0 || (e_par - n_par) != p0 || (e_frm - n_frm) != f0) begin miscompares++; $display("FAIL rand_pulses it=%0d kind=%0d got done/par/frm drift %0d/%0d/%0d", it, kind, (e_done - n_done) - d0, (e_par - n_par) - p0, (e_frm - n_frm) - f0); end
            vectors++; if (count !== 5'(exp_q.size()) || rx_valid !== (exp_q.size() > 0) || overflow !== exp_ovf) begin miscompares++; $display("FAIL rand_state it=%0d got count=%0d valid=%b ovf=%b want %0d/%b/%b", it, count, rx_valid, overflow, exp_q.size(), exp_q.size() > 0, exp_ovf); end
            if (exp_q.size() > 0) begin
                vectors++; if (rx_data !== exp_q[0]) begin miscompares++; $display("FAIL rand_head it=%0d got %h want %h", it, rx_data, exp_q[0]); end
            end
            if ($urandom_range(0, 2) == 0) begin
                npop = $urandom_range(1, 3);
                for (int k = 0; k < npop; k++) pop_one();
                vectors++; if (count !== 5'(exp_q.size())) begin miscompares++; $display("FAIL rand_pop it=%0d got count=%0d want %0d", it, count, exp_q.size()); end
            end
            if (exp_ovf && $urandom_range(0, 1) == 0) begin
                tick(); clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
                exp_ovf = 1'b0;
            end
        end
    endtask

    task automatic test_pulse_rules();
        vectors++; if (n_multi != 0) begin miscompares++; $display("FAIL pulse_exclusive got %0d overlapping cycles want 0", n_multi); end
        vectors++; if (n_long != 0) begin miscompares++; $display("FAIL pulse_width got %0d long pulses want 0", n_long); end
        vectors++; if (n_lat != 0) begin miscompares++; $display("FAIL push_latency got %0d late rx_valid want 0", n_lat); end
        vectors++; if (n_done != e_done || n_par != e_par || n_frm != e_frm) begin miscompares++; $display("FAIL pulse_totals got %0d/%0d/%0d want %0d/%0d/%0d", n_done, n_par, n_frm, e_done, e_par, e_frm); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_stop();
        test_timeout();
        test_overflow();
        test_glitch_reset();
        test_random();
        test_pulse_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
